// File: rtl/data_memory_stage_if.sv
// Handshake and data bundle between the CPU control/datapath and the load/store stage.
// Master drives the request fields, slave (the stage) drives status and results.
// Optional feature macro for the stage: DMEM_ALIGN_CHECK_EN (alignFault is only live with it).
interface data_memory_stage_if;
   logic        start;
   logic        condPass;
   logic        loadStore;
   logic        byteOrWord;
   logic        prePostAddOffset;
   logic        upDownOffset;
   logic        writeBack;
   logic [31:0] rnData;
   logic [31:0] offset;
   logic [31:0] storeData;
   logic        busy;
   logic        done;
   logic        loadValid;
   logic [31:0] loadData;
   logic        baseWriteEn;
   logic [31:0] baseWriteData;
   logic        alignFault;

   modport master (
      output start, condPass, loadStore, byteOrWord, prePostAddOffset, upDownOffset,
             writeBack, rnData, offset, storeData,
      input  busy, done, loadValid, loadData, baseWriteEn, baseWriteData, alignFault
   );

   modport slave (
      input  start, condPass, loadStore, byteOrWord, prePostAddOffset, upDownOffset,
             writeBack, rnData, offset, storeData,
      output busy, done, loadValid, loadData, baseWriteEn, baseWriteData, alignFault
   );
endinterface

// File: rtl/data_memory_stage.sv
// LDR/STR stage: effective address (P/U/W/B), word-organised RAM access, load data and rn writeback.
// Latency: start sampled at edge N -> done visible after edge N+3; one op per 4 cycles.
// No queueing: start is ignored while busy. Macro DMEM_ALIGN_CHECK_EN enables word-alignment faults.
module data_memory_stage #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic              clk,
   input  logic              nreset,
   data_memory_stage_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_MEM, S_RESP} state_t;

   state_t                state_q;
   logic                  cond_q, ld_q, byte_q, pre_q, up_q, wb_q;
   logic [31:0]           rn_q, off_q, sd_q;
   logic [31:0]           off_addr_d, off_addr_q;
   logic [ADDR_WIDTH+1:0] eff_d, eff_q;
   logic [31:0]           rdata_q;
   logic [31:0]           mem_q [DEPTH];

   logic                  busy_q, done_q, load_valid_q, base_we_q;
   logic [31:0]           load_data_q, base_wd_q;

   logic [ADDR_WIDTH-1:0] word_idx;
   logic [1:0]            lane;
   logic [5:0]            rot_sh;
   logic [31:0]           rot_word;
   logic [31:0]           load_fmt;
   logic                  fault;
   logic                  mem_we;

   // Offset arithmetic wraps modulo 2^32; only the RAM-visible address bits are kept for eff.
   always_comb begin
      off_addr_d = up_q ? (rn_q + off_q) : (rn_q - off_q);
      eff_d      = pre_q ? off_addr_d[ADDR_WIDTH+1:0] : rn_q[ADDR_WIDTH+1:0];
   end

   assign word_idx = eff_q[ADDR_WIDTH+1:2];
   assign lane     = eff_q[1:0];

`ifdef DMEM_ALIGN_CHECK_EN
   assign fault = !byte_q && (lane != 2'b00);
`else
   assign fault = 1'b0;
`endif

   // Reset in the MEM cycle suppresses the write so an aborted store leaves RAM untouched.
   assign mem_we = (state_q == S_MEM) && !nreset && cond_q && !ld_q && !fault;

   // Rotate right by 8*lane; a shift of 32 yields 0 so lane 0 is the plain word.
   // The addressed byte of a byte load lands in bits [7:0] of the same rotation.
   always_comb begin
      rot_sh   = {1'b0, lane, 3'b000};
      rot_word = (rdata_q >> rot_sh) | (rdata_q << (6'd32 - rot_sh));
      load_fmt = byte_q ? {24'h0, rot_word[7:0]} : rot_word;
   end

   // Data RAM: registered read and byte-lane write, both in the MEM cycle; contents never reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         if (byte_q) mem_q[word_idx][{lane, 3'b000} +: 8] <= sd_q[7:0];
         else        mem_q[word_idx] <= sd_q;
      end
      if (state_q == S_MEM) rdata_q <= mem_q[word_idx];
   end

`ifdef DMEM_ALIGN_CHECK_EN
   logic align_fault_q;
`endif

   // Control FSM with registered status/result outputs; completion pulses are raised leaving RESP.
   always_ff @(posedge clk) begin
      if (nreset) begin
         state_q      <= S_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         load_valid_q <= 1'b0;
         base_we_q    <= 1'b0;
         load_data_q  <= 32'h0;
         base_wd_q    <= 32'h0;
         cond_q       <= 1'b0;
         ld_q         <= 1'b0;
         byte_q       <= 1'b0;
         pre_q        <= 1'b0;
         up_q         <= 1'b0;
         wb_q         <= 1'b0;
         rn_q         <= 32'h0;
         off_q        <= 32'h0;
         sd_q         <= 32'h0;
         off_addr_q   <= 32'h0;
         eff_q        <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
         align_fault_q <= 1'b0;
`endif
      end else begin
         done_q       <= 1'b0;
         load_valid_q <= 1'b0;
         base_we_q    <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
         align_fault_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  cond_q  <= bus.condPass;
                  ld_q    <= bus.loadStore;
                  byte_q  <= bus.byteOrWord;
                  pre_q   <= bus.prePostAddOffset;
                  up_q    <= bus.upDownOffset;
                  wb_q    <= bus.writeBack;
                  rn_q    <= bus.rnData;
                  off_q   <= bus.offset;
                  sd_q    <= bus.storeData;
                  busy_q  <= 1'b1;
                  state_q <= S_ADDR;
               end
            end
            S_ADDR: begin
               off_addr_q <= off_addr_d;
               eff_q      <= eff_d;
               state_q    <= S_MEM;
            end
            S_MEM: begin
               state_q <= S_RESP;
            end
            S_RESP: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
               if (cond_q && !fault) begin
                  if (ld_q) begin
                     load_valid_q <= 1'b1;
                     load_data_q  <= load_fmt;
                  end
                  if (!pre_q || wb_q) begin
                     base_we_q <= 1'b1;
                     base_wd_q <= off_addr_q;
                  end
               end
`ifdef DMEM_ALIGN_CHECK_EN
               align_fault_q <= cond_q && fault;
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.loadValid     = load_valid_q;
   assign bus.loadData      = load_data_q;
   assign bus.baseWriteEn   = base_we_q;
   assign bus.baseWriteData = base_wd_q;
`ifdef DMEM_ALIGN_CHECK_EN
   assign bus.alignFault    = align_fault_q;
`else
   assign bus.alignFault    = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_stage.sv
// Directed bench for data_memory_stage: expected results queued at issue, checked at done.
// Expectations follow the DMEM_ALIGN_CHECK_EN build setting.
// Ends with a single summary line.
module tb_data_memory_stage;

   typedef struct {
      logic        lv;
      logic [31:0] ld;
      logic        bwe;
      logic [31:0] bwd;
      logic        af;
   } exp_t;

   logic  clk = 1'b0;
   logic  nreset = 1'b1;
   int    n_cmp = 0;
   int    n_fail = 0;
   exp_t  sb[$];
   logic [31:0] last_ld = 32'h0;
   logic  fault_on;

   data_memory_stage_if bus();

   data_memory_stage #(.ADDR_WIDTH(8)) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ".busy"}, {31'h0, bus.busy}, 32'h0);
      chk({tag, ".done"}, {31'h0, bus.done}, 32'h0);
      chk({tag, ".lv"}, {31'h0, bus.loadValid}, 32'h0);
      chk({tag, ".ld"}, bus.loadData, 32'h0);
      chk({tag, ".bwe"}, {31'h0, bus.baseWriteEn}, 32'h0);
      chk({tag, ".bwd"}, bus.baseWriteData, 32'h0);
      chk({tag, ".af"}, {31'h0, bus.alignFault}, 32'h0);
   endtask

   task automatic no_extra_done(input string tag);
      int cnt;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (bus.done) cnt++;
      end
      chk({tag, ".extra_done"}, cnt, 0);
   endtask

   task automatic run_op(input string tag, input logic cp, input logic ld, input logic bt,
                         input logic p, input logic u, input logic w,
                         input logic [31:0] rn, input logic [31:0] off, input logic [31:0] sd,
                         input logic exp_lv, input logic [31:0] exp_ld,
                         input logic exp_bwe, input logic [31:0] exp_bwd,
                         input logic exp_af, input logic poke_busy);
      exp_t e;
      exp_t got_e;
      int   cyc;
      logic seen;
      e.lv  = exp_lv;
      e.ld  = exp_lv ? exp_ld : last_ld;
      e.bwe = exp_bwe;
      e.bwd = exp_bwd;
      e.af  = exp_af;
      last_ld = e.ld;
      sb.push_back(e);

      @(negedge clk);
      bus.condPass = cp; bus.loadStore = ld; bus.byteOrWord = bt;
      bus.prePostAddOffset = p; bus.upDownOffset = u; bus.writeBack = w;
      bus.rnData = rn; bus.offset = off; bus.storeData = sd;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({tag, ".busy"}, {31'h0, bus.busy}, 32'h1);

      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 8) begin
         bus.start = (poke_busy && cyc == 1);
         @(posedge clk); #1;
         cyc++;
         if (bus.done) seen = 1'b1;
      end
      bus.start = 1'b0;
      chk({tag, ".done_seen"}, {31'h0, seen}, 32'h1);
      chk({tag, ".latency"}, cyc, 3);

      if (sb.size() > 0) begin
         got_e = sb.pop_front();
         chk({tag, ".lv"}, {31'h0, bus.loadValid}, {31'h0, got_e.lv});
         chk({tag, ".ld"}, bus.loadData, got_e.ld);
         chk({tag, ".bwe"}, {31'h0, bus.baseWriteEn}, {31'h0, got_e.bwe});
         if (got_e.bwe) chk({tag, ".bwd"}, bus.baseWriteData, got_e.bwd);
         chk({tag, ".af"}, {31'h0, bus.alignFault}, {31'h0, got_e.af});
      end
      chk({tag, ".busy_at_done"}, {31'h0, bus.busy}, 32'h0);

      @(posedge clk); #1;
      chk({tag, ".done_pulse"}, {31'h0, bus.done}, 32'h0);
      chk({tag, ".lv_pulse"}, {31'h0, bus.loadValid}, 32'h0);
      if (poke_busy) no_extra_done(tag);
   endtask

   initial begin
`ifdef DMEM_ALIGN_CHECK_EN
      fault_on = 1'b1;
`else
      fault_on = 1'b0;
`endif
      bus.start = 1'b0; bus.condPass = 1'b0; bus.loadStore = 1'b0; bus.byteOrWord = 1'b0;
      bus.prePostAddOffset = 1'b0; bus.upDownOffset = 1'b0; bus.writeBack = 1'b0;
      bus.rnData = 32'h0; bus.offset = 32'h0; bus.storeData = 32'h0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      nreset = 1'b0;

      // 1: STR word then LDR word at 0x14
      //          tag          cp ld bt p  u  w  rn        off      sd            lv ld            bwe bwd         af poke
      run_op("str_w_14",       1, 0, 0, 1, 1, 0, 32'h10,   32'h4,   32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        0, 0);
      run_op("ldr_w_14",       1, 1, 0, 1, 1, 0, 32'h10,   32'h4,   32'h0,        1, 32'hDEADBEEF, 0, 32'h0,        0, 0);

      // 2: byte store into a lane, word and byte reads
      run_op("str_w_14b",      1, 0, 0, 1, 1, 0, 32'h14,   32'h0,   32'h11223344, 0, 32'h0,        0, 32'h0,        0, 0);
      run_op("str_b_15",       1, 0, 1, 1, 1, 0, 32'h14,   32'h1,   32'h123456AA, 0, 32'h0,        0, 32'h0,        0, 0);
      run_op("ldr_w_14c",      1, 1, 0, 1, 1, 0, 32'h14,   32'h0,   32'h0,        1, 32'h1122AA44, 0, 32'h0,        0, 0);
      run_op("ldr_b_16",       1, 1, 1, 1, 1, 0, 32'h14,   32'h2,   32'h0,        1, 32'h00000022, 0, 32'h0,        0, 0);

      // 3: post-index and pre-index with writeback
      run_op("str_w_20",       1, 0, 0, 1, 1, 0, 32'h20,   32'h0,   32'h11223344, 0, 32'h0,        0, 32'h0,        0, 0);
      run_op("str_w_28",       1, 0, 0, 1, 1, 0, 32'h28,   32'h0,   32'hCAFEF00D, 0, 32'h0,        0, 32'h0,        0, 0);
      run_op("ldr_post",       1, 1, 0, 0, 0, 0, 32'h20,   32'h8,   32'h0,        1, 32'h11223344, 1, 32'h18,       0, 0);
      run_op("ldr_pre_wb",     1, 1, 0, 1, 1, 1, 32'h20,   32'h8,   32'h0,        1, 32'hCAFEF00D, 1, 32'h28,       0, 0);

      // 4: unaligned word accesses
      if (fault_on) begin
         run_op("ldr_unal_21", 1, 1, 0, 1, 1, 0, 32'h20,   32'h1,   32'h0,        0, 32'h0,        0, 32'h0,        1, 0);
         run_op("str_unal_23", 1, 0, 0, 1, 1, 1, 32'h20,   32'h3,   32'h55667788, 0, 32'h0,        0, 32'h0,        1, 0);
         run_op("ldr_w_20",    1, 1, 0, 1, 1, 0, 32'h20,   32'h0,   32'h0,        1, 32'h11223344, 0, 32'h0,        0, 0);
      end else begin
         run_op("ldr_unal_21", 1, 1, 0, 1, 1, 0, 32'h20,   32'h1,   32'h0,        1, 32'h44112233, 0, 32'h0,        0, 0);
         run_op("str_unal_23", 1, 0, 0, 1, 1, 1, 32'h20,   32'h3,   32'h55667788, 0, 32'h0,        1, 32'h23,       0, 0);
         run_op("ldr_w_20",    1, 1, 0, 1, 1, 0, 32'h20,   32'h0,   32'h0,        1, 32'h55667788, 0, 32'h0,        0, 0);
      end

      // 5: condition failed store, start pulsed while busy
      run_op("str_w_30",       1, 0, 0, 1, 1, 0, 32'h30,   32'h0,   32'h12345678, 0, 32'h0,        0, 32'h0,        0, 0);
      run_op("str_nocond",     0, 0, 0, 1, 1, 1, 32'h30,   32'h0,   32'hFFFFFFFF, 0, 32'h0,        0, 32'h0,        0, 1);
      run_op("ldr_w_30",       1, 1, 0, 1, 1, 0, 32'h30,   32'h0,   32'h0,        1, 32'h12345678, 0, 32'h0,        0, 0);

      // wrap of offset arithmetic, address aliasing above the RAM size
      run_op("str_wrap",       1, 0, 0, 0, 0, 0, 32'h0,    32'h4,   32'hA5A5A5A5, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 0);
      run_op("ldr_alias_400",  1, 1, 0, 1, 1, 0, 32'h400,  32'h0,   32'h0,        1, 32'hA5A5A5A5, 0, 32'h0,        0, 0);

      // 6: reset asserted while a store sits in MEM
      @(negedge clk);
      bus.condPass = 1'b1; bus.loadStore = 1'b0; bus.byteOrWord = 1'b0;
      bus.prePostAddOffset = 1'b0; bus.upDownOffset = 1'b1; bus.writeBack = 1'b0;
      bus.rnData = 32'h40; bus.offset = 32'h4; bus.storeData = 32'h0BADF00D;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      nreset = 1'b1;
      @(posedge clk); #1;
      nreset = 1'b0;
      chk_idle_outputs("mid_reset");
      last_ld = 32'h0;
      no_extra_done("mid_reset");
      run_op("ldr_after_rst",  1, 1, 0, 1, 1, 0, 32'h400,  32'h0,   32'h0,        1, 32'hA5A5A5A5, 0, 32'h0,        0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
